// File: rtl/i2c_arbiter.sv
// i2c_arbiter
//   Round-robin, bus-locking arbiter that shares one I2C register-access controller between
//   NUM_CLIENTS sensor clients. A client keeps its grant for as long as it holds cl_req, so
//   multi-transaction sequences (pointer write, then burst read) stay atomic. The request fields
//   of the granted client are muxed to the controller. Controller returns are routed back to the
//   granted client only.
//
// Parameters
//   NUM_CLIENTS  number of requesters (2..8)
//   HOLD_LIMIT   completed transactions allowed per grant while another client waits; 0 = no limit
//
// Ports
//   clk, rst                       clock, asynchronous active-high reset
//   cl_req[N]                      level request / keep-bus per client
//   cl_gnt[N]                      registered one-hot grant
//   cl_enable[N]                   per-client transaction start
//   cl_reg_addr/len/wrdata/rdwr    flattened per-client request fields (client k at slice k)
//   cl_strobe/done/rd_done/ack[N]  controller returns, gated to the granted client
//   cl_rddata[8]                   controller read data, broadcast while a grant is held
//   i2c_*                          controller side: muxed request out, returns in
//   err_drop                       1-cycle pulse: cl_enable seen from a non-granted client
module i2c_arbiter #(
   parameter int unsigned NUM_CLIENTS = 2,
   parameter int unsigned HOLD_LIMIT  = 0
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic [NUM_CLIENTS-1:0]   cl_req,
   output logic [NUM_CLIENTS-1:0]   cl_gnt,
   input  logic [NUM_CLIENTS-1:0]   cl_enable,
   input  logic [8*NUM_CLIENTS-1:0] cl_reg_addr,
   input  logic [5*NUM_CLIENTS-1:0] cl_reg_len,
   input  logic [8*NUM_CLIENTS-1:0] cl_reg_wrdata,
   input  logic [NUM_CLIENTS-1:0]   cl_reg_rdwr,
   output logic [NUM_CLIENTS-1:0]   cl_strobe,
   output logic [NUM_CLIENTS-1:0]   cl_done,
   output logic [NUM_CLIENTS-1:0]   cl_rd_done,
   output logic [NUM_CLIENTS-1:0]   cl_ack,
   output logic [7:0]               cl_rddata,
   input  logic                     i2c_strobe,
   output logic                     i2c_enable,
   output logic [7:0]               i2c_reg_addr,
   output logic [4:0]               i2c_reg_len,
   output logic [7:0]               i2c_reg_wrdata,
   output logic                     i2c_reg_rdwr,
   input  logic [7:0]               i2c_reg_rddata,
   input  logic                     i2c_done,
   input  logic                     i2c_rd_done,
   input  logic                     i2c_ack,
   output logic                     err_drop
);

   localparam int unsigned IW = (NUM_CLIENTS > 1) ? $clog2(NUM_CLIENTS) : 1;

   localparam logic [1:0] StIdle  = 2'd0;
   localparam logic [1:0] StOwn   = 2'd1;
   localparam logic [1:0] StDrain = 2'd2;

   logic [1:0]             state_q, state_d;
   logic [NUM_CLIENTS-1:0] gnt_q, gnt_d;
   logic [IW-1:0]          idx_q, idx_d;
   logic [IW-1:0]          ptr_q, ptr_d;
   logic                   busy_q, busy_d;
   logic [7:0]             cnt_q, cnt_d;
   logic                   err_q, err_d;

   logic          req_g, en_g, others_req, start, release_own, found;
   logic [IW-1:0] cand;

   // Everything is keyed off the one-hot grant, so no index decode is needed on the data path.
   assign req_g      = |(cl_req & gnt_q);
   assign en_g       = |(cl_enable & gnt_q);
   assign others_req = |(cl_req & ~gnt_q);

   // Enables only pass while owning; DRAIN blocks new transactions from the departing client.
   assign i2c_enable = (state_q == StOwn) && en_g;
   assign start      = i2c_enable && i2c_strobe;

   always_comb begin
      i2c_reg_addr   = '0;
      i2c_reg_len    = '0;
      i2c_reg_wrdata = '0;
      i2c_reg_rdwr   = 1'b0;
      for (int k = 0; k < NUM_CLIENTS; k++) begin
         if (gnt_q[k]) begin
            i2c_reg_addr   = cl_reg_addr[8*k +: 8];
            i2c_reg_len    = cl_reg_len[5*k +: 5];
            i2c_reg_wrdata = cl_reg_wrdata[8*k +: 8];
            i2c_reg_rdwr   = cl_reg_rdwr[k];
         end
      end
   end

   assign cl_gnt     = gnt_q;
   assign cl_strobe  = {NUM_CLIENTS{i2c_strobe}} & gnt_q;
   assign cl_done    = {NUM_CLIENTS{i2c_done}} & gnt_q;
   assign cl_rd_done = {NUM_CLIENTS{i2c_rd_done}} & gnt_q;
   assign cl_ack     = {NUM_CLIENTS{i2c_ack}} & gnt_q;
   assign cl_rddata  = (|gnt_q) ? i2c_reg_rddata : 8'h00;
   assign err_drop   = err_q;

   always_comb begin
      state_d     = state_q;
      gnt_d       = gnt_q;
      idx_d       = idx_q;
      ptr_d       = ptr_q;
      busy_d      = busy_q;
      cnt_d       = cnt_q;
      release_own = 1'b0;
      found       = 1'b0;
      cand        = '0;
      err_d       = |(cl_enable & ~gnt_q);

      unique case (state_q)
         StIdle: begin
            // First requester at or after the pointer, wrapping.
            for (int i = 0; i < NUM_CLIENTS; i++) begin
               cand = IW'((int'(ptr_q) + i) % int'(NUM_CLIENTS));
               if (!found && cl_req[cand]) begin
                  found        = 1'b1;
                  idx_d        = cand;
                  gnt_d        = '0;
                  gnt_d[cand]  = 1'b1;
               end
            end
            if (found) begin
               state_d = StOwn;
               busy_d  = 1'b0;
               cnt_d   = '0;
            end
         end
         StOwn: begin
            // done wins over a start in the same cycle
            busy_d = i2c_done ? 1'b0 : (start ? 1'b1 : busy_q);
            if (i2c_done && cnt_q != 8'hFF) begin
               cnt_d = cnt_q + 8'd1;
            end
            // Decisions use the updated busy so a start in the release cycle is never orphaned.
            if (!req_g) begin
               if (busy_d) begin
                  state_d = StDrain;
               end else begin
                  release_own = 1'b1;
               end
            end else if (HOLD_LIMIT != 0 && 32'(cnt_q) >= HOLD_LIMIT && others_req && !busy_d)
            begin
               release_own = 1'b1;
            end
         end
         StDrain: begin
            busy_d = busy_q & ~i2c_done;
            if (i2c_done) begin
               release_own = 1'b1;
            end
         end
         default: begin
            state_d = StIdle;
            gnt_d   = '0;
         end
      endcase

      // Releasing always passes through IDLE, giving one dead cycle before the next grant.
      if (release_own) begin
         state_d = StIdle;
         gnt_d   = '0;
         busy_d  = 1'b0;
         cnt_d   = '0;
         ptr_d   = (idx_q == IW'(NUM_CLIENTS - 1)) ? '0 : idx_q + 1'b1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= StIdle;
         gnt_q   <= '0;
         idx_q   <= '0;
         ptr_q   <= '0;
         busy_q  <= 1'b0;
         cnt_q   <= '0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         gnt_q   <= gnt_d;
         idx_q   <= idx_d;
         ptr_q   <= ptr_d;
         busy_q  <= busy_d;
         cnt_q   <= cnt_d;
         err_q   <= err_d;
      end
   end

endmodule

// File: tb/tb_i2c_arbiter.sv
module tb_i2c_arbiter;

   localparam int N    = 2;
   localparam int HOLD = 2;

   logic           clk = 1'b0;
   logic           rst;
   logic [N-1:0]   cl_req, cl_gnt, cl_enable, cl_reg_rdwr;
   logic [N-1:0]   cl_strobe, cl_done, cl_rd_done, cl_ack;
   logic [8*N-1:0] cl_reg_addr, cl_reg_wrdata;
   logic [5*N-1:0] cl_reg_len;
   logic [7:0]     cl_rddata;
   logic           i2c_strobe, i2c_enable, i2c_reg_rdwr, i2c_done, i2c_rd_done, i2c_ack;
   logic [7:0]     i2c_reg_addr, i2c_reg_wrdata, i2c_reg_rddata;
   logic [4:0]     i2c_reg_len;
   logic           err_drop;

   int n_pass = 0;
   int n_chk  = 0;

   always #5 clk = ~clk;

   i2c_arbiter #(.NUM_CLIENTS(N), .HOLD_LIMIT(HOLD)) dut (
      .clk(clk), .rst(rst),
      .cl_req(cl_req), .cl_gnt(cl_gnt), .cl_enable(cl_enable),
      .cl_reg_addr(cl_reg_addr), .cl_reg_len(cl_reg_len), .cl_reg_wrdata(cl_reg_wrdata),
      .cl_reg_rdwr(cl_reg_rdwr),
      .cl_strobe(cl_strobe), .cl_done(cl_done), .cl_rd_done(cl_rd_done), .cl_ack(cl_ack),
      .cl_rddata(cl_rddata),
      .i2c_strobe(i2c_strobe), .i2c_enable(i2c_enable), .i2c_reg_addr(i2c_reg_addr),
      .i2c_reg_len(i2c_reg_len), .i2c_reg_wrdata(i2c_reg_wrdata), .i2c_reg_rdwr(i2c_reg_rdwr),
      .i2c_reg_rddata(i2c_reg_rddata), .i2c_done(i2c_done), .i2c_rd_done(i2c_rd_done),
      .i2c_ack(i2c_ack), .err_drop(err_drop)
   );

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", nm, act, exp, $time);
   endtask

   task automatic nxt();
      @(posedge clk);
      #1;
   endtask

   // Reference model: who owns the bus, whether it is draining, and where the search starts.
   int   m_owner;
   bit   m_drain, m_busy, m_err;
   int   m_cnt, m_ptr;

   task automatic model_reset();
      m_owner = -1; m_drain = 0; m_busy = 0; m_err = 0; m_cnt = 0; m_ptr = 0;
   endtask

   function automatic logic [N-1:0] model_gnt();
      return (m_owner >= 0) ? (N'(1) << m_owner) : '0;
   endfunction

   task automatic model_step();
      logic [N-1:0] gm;
      bit started, bnext, rel, fnd;
      gm = model_gnt();
      m_err = |(cl_enable & ~gm);
      if (m_owner < 0) begin
         fnd = 0;
         for (int i = 0; i < N; i++) begin
            int c;
            c = (m_ptr + i) % N;
            if (!fnd && cl_req[c]) begin
               fnd = 1; m_owner = c;
            end
         end
         m_drain = 0; m_busy = 0; m_cnt = 0;
      end else begin
         started = !m_drain && cl_enable[m_owner] && i2c_strobe;
         bnext   = i2c_done ? 1'b0 : (started ? 1'b1 : m_busy);
         rel     = 0;
         if (m_drain) rel = i2c_done;
         else if (!cl_req[m_owner]) begin
            if (bnext) m_drain = 1;
            else rel = 1;
         end else if (HOLD > 0 && m_cnt >= HOLD && (cl_req & ~gm) != 0 && !bnext) rel = 1;
         m_busy = bnext;
         if (i2c_done) m_cnt++;
         if (rel) begin
            m_ptr = (m_owner + 1) % N;
            m_owner = -1; m_drain = 0; m_busy = 0; m_cnt = 0;
         end
      end
   endtask

   task automatic model_compare();
      logic [N-1:0] gm;
      logic [7:0]   ea, ew, er;
      logic [4:0]   el;
      logic         een, erw;
      gm = model_gnt();
      ea = 0; ew = 0; el = 0; erw = 0; een = 0; er = 0;
      if (m_owner >= 0) begin
         ea  = cl_reg_addr[8*m_owner +: 8];
         ew  = cl_reg_wrdata[8*m_owner +: 8];
         el  = cl_reg_len[5*m_owner +: 5];
         erw = cl_reg_rdwr[m_owner];
         een = m_drain ? 1'b0 : cl_enable[m_owner];
         er  = i2c_reg_rddata;
      end
      chk("rnd_gnt", 32'(cl_gnt), 32'(gm));
      chk("rnd_err", 32'(err_drop), 32'(m_err));
      chk("rnd_en", 32'(i2c_enable), 32'(een));
      chk("rnd_addr", 32'(i2c_reg_addr), 32'(ea));
      chk("rnd_wrdata", 32'(i2c_reg_wrdata), 32'(ew));
      chk("rnd_len", 32'(i2c_reg_len), 32'(el));
      chk("rnd_rdwr", 32'(i2c_reg_rdwr), 32'(erw));
      chk("rnd_strobe", 32'(cl_strobe), 32'({N{i2c_strobe}} & gm));
      chk("rnd_done", 32'(cl_done), 32'({N{i2c_done}} & gm));
      chk("rnd_rd_done", 32'(cl_rd_done), 32'({N{i2c_rd_done}} & gm));
      chk("rnd_ack", 32'(cl_ack), 32'({N{i2c_ack}} & gm));
      chk("rnd_rddata", 32'(cl_rddata), 32'(er));
   endtask

   task automatic do_reset();
      rst = 1'b1;
      cl_req = '0; cl_enable = '0; cl_reg_rdwr = '0;
      cl_reg_addr = '0; cl_reg_wrdata = '0; cl_reg_len = '0;
      i2c_strobe = 0; i2c_done = 0; i2c_rd_done = 0; i2c_ack = 0; i2c_reg_rddata = '0;
      model_reset();
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
   endtask

   // Controller-return pulse for the single-client sequence, tallying what each client sees.
   int n_done1, n_done0, n_rd1;
   task automatic pulse(input logic dn, input logic rd, input logic [7:0] data);
      i2c_done = dn; i2c_rd_done = rd; i2c_reg_rddata = data;
      @(negedge clk);
      n_done1 += int'(cl_done[1]);
      n_done0 += int'(cl_done[0]);
      n_rd1   += int'(cl_rd_done[1]);
      if (rd) chk("single_rddata", 32'(cl_rddata), 32'(data));
      nxt();
      i2c_done = 0; i2c_rd_done = 0;
   endtask

   typedef struct {
      logic [1:0] req;
      logic [1:0] en;
      logic       st;
      logic       dn;
      logic [1:0] gnt;
      logic       ien;
      logic       err;
      logic [1:0] cst;
      logic [1:0] cdn;
      logic [7:0] addr;
   } vec_t;

   vec_t vt[13];

   initial begin
      // req    en     st    dn    | gnt   ien   err   cst    cdn    addr
      vt[0]  = '{2'b11, 2'b00, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 2'b00, 2'b00, 8'h00};
      vt[1]  = '{2'b11, 2'b01, 1'b1, 1'b0, 2'b01, 1'b1, 1'b0, 2'b01, 2'b00, 8'h11};
      vt[2]  = '{2'b11, 2'b00, 1'b0, 1'b1, 2'b01, 1'b0, 1'b0, 2'b00, 2'b01, 8'h11};
      vt[3]  = '{2'b10, 2'b00, 1'b0, 1'b0, 2'b01, 1'b0, 1'b0, 2'b00, 2'b00, 8'h11};
      vt[4]  = '{2'b11, 2'b00, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 2'b00, 2'b00, 8'h00};
      vt[5]  = '{2'b11, 2'b10, 1'b1, 1'b0, 2'b10, 1'b1, 1'b0, 2'b10, 2'b00, 8'h22};
      vt[6]  = '{2'b01, 2'b00, 1'b0, 1'b0, 2'b10, 1'b0, 1'b0, 2'b00, 2'b00, 8'h22};
      vt[7]  = '{2'b01, 2'b10, 1'b1, 1'b0, 2'b10, 1'b0, 1'b0, 2'b10, 2'b00, 8'h22};
      vt[8]  = '{2'b01, 2'b00, 1'b0, 1'b1, 2'b10, 1'b0, 1'b0, 2'b00, 2'b10, 8'h22};
      vt[9]  = '{2'b11, 2'b10, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 2'b00, 2'b00, 8'h00};
      vt[10] = '{2'b11, 2'b00, 1'b0, 1'b0, 2'b01, 1'b0, 1'b1, 2'b00, 2'b00, 8'h11};
      vt[11] = '{2'b11, 2'b10, 1'b0, 1'b0, 2'b01, 1'b0, 1'b0, 2'b00, 2'b00, 8'h11};
      vt[12] = '{2'b11, 2'b01, 1'b0, 1'b0, 2'b01, 1'b1, 1'b1, 2'b00, 2'b00, 8'h11};

      // Contention, drop-while-busy drain and illegal enable, one row per cycle.
      do_reset();
      cl_reg_addr = 16'h2211;
      for (int r = 0; r < 13; r++) begin
         cl_req = vt[r].req; cl_enable = vt[r].en; i2c_strobe = vt[r].st; i2c_done = vt[r].dn;
         @(negedge clk);
         chk($sformatf("vec%0d_gnt", r), 32'(cl_gnt), 32'(vt[r].gnt));
         chk($sformatf("vec%0d_en", r), 32'(i2c_enable), 32'(vt[r].ien));
         chk($sformatf("vec%0d_err", r), 32'(err_drop), 32'(vt[r].err));
         chk($sformatf("vec%0d_strobe", r), 32'(cl_strobe), 32'(vt[r].cst));
         chk($sformatf("vec%0d_done", r), 32'(cl_done), 32'(vt[r].cdn));
         chk($sformatf("vec%0d_addr", r), 32'(i2c_reg_addr), 32'(vt[r].addr));
         nxt();
      end

      // Reset in the middle of a read owned by client 1 (pointer at 1).
      do_reset();
      cl_req = 2'b01; nxt();
      cl_req = 2'b00; nxt();
      cl_req = 2'b10; nxt();
      cl_enable = 2'b10; i2c_strobe = 1; cl_reg_rdwr = 2'b10; nxt();
      i2c_strobe = 0; cl_enable = 2'b01; nxt();
      cl_enable = 2'b10;
      #1;
      chk("rst_pre_gnt", 32'(cl_gnt), 32'(2'b10));
      chk("rst_pre_en", 32'(i2c_enable), 32'(1));
      chk("rst_pre_err", 32'(err_drop), 32'(1));
      rst = 1'b1;
      #1;
      chk("rst_gnt", 32'(cl_gnt), 32'(0));
      chk("rst_en", 32'(i2c_enable), 32'(0));
      chk("rst_err", 32'(err_drop), 32'(0));
      cl_enable = '0; cl_req = 2'b11; cl_reg_rdwr = '0;
      nxt(); nxt();
      rst = 1'b0;
      @(negedge clk);
      chk("rst_idle_gnt", 32'(cl_gnt), 32'(0));
      nxt();
      chk("rst_first_gnt", 32'(cl_gnt), 32'(2'b01));

      // Single client: pointer write then burst read, held across both.
      do_reset();
      n_done1 = 0; n_done0 = 0; n_rd1 = 0;
      cl_req = 2'b10;
      cl_reg_addr = 16'hFA00; cl_reg_len = {5'd2, 5'd0}; cl_reg_wrdata = 16'h5A00;
      #1;
      chk("single_idle_addr", 32'(i2c_reg_addr), 32'(0));
      nxt();
      chk("single_gnt", 32'(cl_gnt), 32'(2'b10));
      cl_enable = 2'b10; i2c_strobe = 1;
      #1;
      chk("single_wr_en", 32'(i2c_enable), 32'(1));
      chk("single_wr_addr", 32'(i2c_reg_addr), 32'(8'hFA));
      chk("single_wr_len", 32'(i2c_reg_len), 32'(2));
      chk("single_wr_data", 32'(i2c_reg_wrdata), 32'(8'h5A));
      chk("single_wr_rdwr", 32'(i2c_reg_rdwr), 32'(0));
      nxt();
      cl_enable = '0; i2c_strobe = 0;
      pulse(0, 0, 8'h00);
      pulse(1, 0, 8'h00);
      cl_reg_len = {5'd4, 5'd0}; cl_reg_rdwr = 2'b10; cl_enable = 2'b10; i2c_strobe = 1;
      #1;
      chk("single_rd_len", 32'(i2c_reg_len), 32'(4));
      chk("single_rd_rdwr", 32'(i2c_reg_rdwr), 32'(1));
      nxt();
      cl_enable = '0; i2c_strobe = 0;
      pulse(0, 1, 8'hA1);
      pulse(0, 1, 8'hB2);
      pulse(0, 0, 8'h00);
      pulse(0, 1, 8'hC3);
      pulse(1, 0, 8'h00);
      chk("single_done1", 32'(n_done1), 32'(2));
      chk("single_rd_done1", 32'(n_rd1), 32'(3));
      chk("single_done0", 32'(n_done0), 32'(0));
      nxt();
      chk("single_still_gnt", 32'(cl_gnt), 32'(2'b10));

      // Hold limit: client 0 keeps requesting while client 1 waits.
      do_reset();
      cl_req = 2'b01; nxt();
      cl_req = 2'b11;
      #1;
      chk("hold_gnt0", 32'(cl_gnt), 32'(2'b01));
      for (int t = 0; t < 2; t++) begin
         cl_enable = 2'b01; i2c_strobe = 1; nxt();
         cl_enable = '0; i2c_strobe = 0; i2c_done = 1; nxt();
         i2c_done = 0;
         #1;
         chk($sformatf("hold_after_done%0d", t), 32'(cl_gnt), 32'(2'b01));
      end
      nxt();
      chk("hold_released", 32'(cl_gnt), 32'(0));
      nxt();
      chk("hold_gnt1", 32'(cl_gnt), 32'(2'b10));

      // Randomised traffic against the reference model.
      do_reset();
      for (int c = 0; c < 3000; c++) begin
         for (int k = 0; k < N; k++) begin
            if ($urandom_range(9) == 0) cl_req[k] = ~cl_req[k];
            cl_enable[k] = ($urandom_range(2) == 0);
         end
         cl_reg_addr    = 16'($urandom);
         cl_reg_wrdata  = 16'($urandom);
         cl_reg_len     = 10'($urandom);
         cl_reg_rdwr    = 2'($urandom);
         i2c_strobe     = 1'($urandom_range(1));
         i2c_done       = ($urandom_range(4) == 0);
         i2c_rd_done    = 1'($urandom_range(1));
         i2c_ack        = 1'($urandom_range(1));
         i2c_reg_rddata = 8'($urandom);
         @(negedge clk);
         model_compare();
         model_step();
         nxt();
      end

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
